// File: rtl/sequenciador_instr_if.sv
// Instruction stream between the issuer and the core.
// Issuer drives instr/instr_valid; the core drives instr_ready.
interface sequenciador_instr_if;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;

  modport master (
    output instr,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  instr,
    input  instr_valid,
    output instr_ready
  );
endinterface

// File: rtl/sequenciador_instr.sv
// Instruction issuer: program memory, PC and valid/ready issue FSM.
// Optional single-step control is compiled in with SEQ_STEP_EN.
module sequenciador_instr #(
  parameter int          ADDR_W  = 4,
  parameter logic [7:0]  HALT_OP = 8'h13,
  parameter logic [7:0]  NOP_OP  = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_data,
`ifdef SEQ_STEP_EN
  input  logic              step,
  input  logic              step_mode,
`endif
  sequenciador_instr_if.master bus,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    HALTED
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  logic [7:0]        mem [2**ADDR_W];
  logic [7:0]        word;
  logic              load;
  logic              fetch;
  logic              xfer;

  // Not reset: the program survives rst.
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end

  assign word = mem[pc_q];
  assign load = !valid_q || bus.instr_ready;
  assign xfer = valid_q && bus.instr_ready;

`ifdef SEQ_STEP_EN
  assign fetch = load && (!step_mode || step);
`else
  assign fetch = load;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      instr_q <= NOP_OP;
      valid_q <= 1'b0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      RUN: begin
        if (fetch) begin
          instr_d = word;
          valid_d = 1'b1;
          pc_d    = pc_q + ADDR_W'(1);
          if (word == HALT_OP) state_d = DRAIN;
        end else if (xfer) begin
          // Step mode: accepted word retires without a refill.
          instr_d = NOP_OP;
          valid_d = 1'b0;
        end
      end
      DRAIN: begin
        if (xfer) begin
          state_d = HALTED;
          instr_d = NOP_OP;
          valid_d = 1'b0;
        end
      end
      HALTED: begin
        if (start) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign pc              = pc_q;
  assign busy            = (state_q == RUN) || (state_q == DRAIN);
  assign halted          = (state_q == HALTED);

endmodule

// File: tb/tb_sequenciador_instr.sv
// Directed bench for sequenciador_instr.
// Step-mode vectors are included when SEQ_STEP_EN is defined.
module tb_sequenciador_instr;

  logic       clk;
  logic       rst;
  logic       start;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [3:0] pc;
  logic       busy;
  logic       halted;
`ifdef SEQ_STEP_EN
  logic       step;
  logic       step_mode;
`endif

  int n_chk;
  int n_pass;

  sequenciador_instr_if bus ();

  sequenciador_instr dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
`ifdef SEQ_STEP_EN
    .step      (step),
    .step_mode (step_mode),
`endif
    .bus       (bus.master),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    prog_we   = 1'b1;
    prog_addr = 4'(a);
    prog_data = 8'(d);
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic out(input string tag, input int ins, input int v, input int p);
    chk({tag, ".instr"}, int'(bus.instr), ins);
    chk({tag, ".valid"}, int'(bus.instr_valid), v);
    chk({tag, ".pc"}, int'(pc), p);
  endtask

  initial begin
    n_chk           = 0;
    n_pass          = 0;
    rst             = 1'b1;
    start           = 1'b0;
    prog_we         = 1'b0;
    prog_addr       = '0;
    prog_data       = '0;
    bus.instr_ready = 1'b1;
`ifdef SEQ_STEP_EN
    step            = 1'b0;
    step_mode       = 1'b0;
`endif
    tick();
    tick();
    out("rst", 'hFF, 0, 0);
    chk("rst.busy", int'(busy), 0);
    chk("rst.halted", int'(halted), 0);
    rst = 1'b0;

    // Basic run: 00,01,13
    wr(0, 'h00);
    wr(1, 'h01);
    wr(2, 'h13);
    pulse_start();
    chk("lat.valid", int'(bus.instr_valid), 0);
    chk("lat.busy", int'(busy), 1);
    tick();
    out("run0", 'h00, 1, 1);
    tick();
    out("run1", 'h01, 1, 2);
    tick();
    out("run2", 'h13, 1, 3);
    chk("run2.busy", int'(busy), 1);
    tick();
    out("halt", 'hFF, 0, 3);
    chk("halt.halted", int'(halted), 1);
    chk("halt.busy", int'(busy), 0);

    // Back-pressure after the first valid word
    bus.instr_ready = 1'b0;
    pulse_start();
    chk("bp.halted", int'(halted), 0);
    tick();
    out("bp0", 'h00, 1, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      out("bp.hold", 'h00, 1, 1);
    end
    bus.instr_ready = 1'b1;
    tick();
    out("bp1", 'h01, 1, 2);
    tick();
    out("bp2", 'h13, 1, 3);
    tick();
    chk("bp.halted2", int'(halted), 1);

    // Rewrite while halted
    wr(0, 'h07);
    pulse_start();
    chk("rw.halted", int'(halted), 0);
    tick();
    out("rw0", 'h07, 1, 1);
    tick();
    tick();
    tick();
    chk("rw.halted2", int'(halted), 1);

    // Wrap-around with no HALT in memory
    for (int a = 0; a < 15; a++) wr(a, 'h0C);
    wr(15, 'h05);
    pulse_start();
    for (int k = 0; k <= 16; k++) begin
      tick();
      if (k == 0)  out("wrap0", 'h0C, 1, 1);
      if (k == 15) out("wrap15", 'h05, 1, 0);
      if (k == 16) begin
        out("wrap16", 'h0C, 1, 1);
        chk("wrap.busy", int'(busy), 1);
      end
    end

    // Reset mid-run at pc=2, memory retained
    rst = 1'b1;
    #1;
    out("rstw", 'hFF, 0, 0);
    rst = 1'b0;
    wr(0, 'h00);
    wr(1, 'h01);
    wr(2, 'h13);
    pulse_start();
    tick();
    tick();
    chk("mid.pc", int'(pc), 2);
    rst = 1'b1;
    #1;
    out("mid", 'hFF, 0, 0);
    chk("mid.busy", int'(busy), 0);
    rst = 1'b0;
    tick();
    pulse_start();
    tick();
    out("ret0", 'h00, 1, 1);
    tick();
    out("ret1", 'h01, 1, 2);
    tick();
    out("ret2", 'h13, 1, 3);
    tick();
    chk("ret.halted", int'(halted), 1);

`ifdef SEQ_STEP_EN
    begin
      int n_x;
      n_x       = 0;
      step_mode = 1'b1;
      pulse_start();
      for (int c = 0; c < 10; c++) begin
        step = (c == 2) || (c == 5);
        tick();
        step = 1'b0;
        if (bus.instr_valid && bus.instr_ready) n_x++;
      end
      chk("step.xfers", n_x, 2);
      chk("step.pc", int'(pc), 2);
      chk("step.busy", int'(busy), 1);
      step_mode = 1'b0;
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
